// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking
// and line/frame start strobes, all aligned to the counts they accompany.
module video_sync_gen #(
  parameter int HSIZE     = 11,
  parameter int VSIZE     = 11,
  parameter int HDISPLAY  = 640,
  parameter int HFP       = 16,
  parameter int HSP       = 96,
  parameter int HBP       = 48,
  parameter int VDISPLAY  = 480,
  parameter int VFP       = 10,
  parameter int VSP       = 2,
  parameter int VBP       = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [HSIZE-1:0] hc,
  output logic [VSIZE-1:0] vc,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int HTOTAL = HDISPLAY + HFP + HSP + HBP;
  localparam int VTOTAL = VDISPLAY + VFP + VSP + VBP;

  localparam logic [HSIZE-1:0] H_LAST = HSIZE'(HTOTAL - 1);
  localparam logic [HSIZE-1:0] H_DISP = HSIZE'(HDISPLAY);
  localparam logic [HSIZE-1:0] H_SS   = HSIZE'(HDISPLAY + HFP);
  localparam logic [HSIZE-1:0] H_SE   = HSIZE'(HDISPLAY + HFP + HSP - 1);
  localparam logic [VSIZE-1:0] V_LAST = VSIZE'(VTOTAL - 1);
  localparam logic [VSIZE-1:0] V_DISP = VSIZE'(VDISPLAY);
  localparam logic [VSIZE-1:0] V_SS   = VSIZE'(VDISPLAY + VFP);
  localparam logic [VSIZE-1:0] V_SE   = VSIZE'(VDISPLAY + VFP + VSP - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (((HTOTAL - 1) >> HSIZE) != 0) begin : g_bad_hsize
    $error("video_sync_gen: HTOTAL-1 does not fit in HSIZE bits");
  end
  if (((VTOTAL - 1) >> VSIZE) != 0) begin : g_bad_vsize
    $error("video_sync_gen: VTOTAL-1 does not fit in VSIZE bits");
  end
  if (HFP <= 0 || HSP <= 0 || HBP <= 0 || VFP <= 0 || VSP <= 0 || VBP <= 0) begin : g_bad_len
    $error("video_sync_gen: porch and sync lengths must be non-zero");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [HSIZE-1:0] hc_nxt;
  logic [VSIZE-1:0] vc_nxt;

  always_comb begin
    h_wrap = (hc == H_LAST);
    v_wrap = (vc == V_LAST);
    hc_nxt = hc;
    vc_nxt = vc;
    if (pix_en) begin
      hc_nxt = h_wrap ? '0 : hc + 1'b1;
      if (h_wrap) begin
        vc_nxt = v_wrap ? '0 : vc + 1'b1;
      end
    end
  end

  // Decoding the next counts keeps the registered flags in step with hc/vc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      video_on    <= (hc_nxt < H_DISP) && (vc_nxt < V_DISP);
      hsync       <= ((hc_nxt >= H_SS) && (hc_nxt <= H_SE)) ? HS_ON : ~HS_ON;
      vsync       <= ((vc_nxt >= V_SS) && (vc_nxt <= V_SE)) ? VS_ON : ~VS_ON;
      line_start  <= pix_en && h_wrap;
      frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: two small-raster instances (both sync polarities)
// and one default-timing instance checked every clock against a reference model.
module tb_video_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  a_hc, b_hc;
  logic [2:0]  a_vc, b_vc;
  logic [10:0] d_hc, d_vc;
  logic a_hs, a_vs, a_von, a_ls, a_fs;
  logic b_hs, b_vs, b_von, b_ls, b_fs;
  logic d_hs, d_vs, d_von, d_ls, d_fs;

  video_sync_gen #(.HSIZE(4), .VSIZE(3), .HDISPLAY(8), .HFP(2), .HSP(3), .HBP(2),
                   .VDISPLAY(4), .VFP(1), .VSP(2), .VBP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hc(a_hc), .vc(a_vc),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls), .frame_start(a_fs));

  video_sync_gen #(.HSIZE(4), .VSIZE(3), .HDISPLAY(8), .HFP(2), .HSP(3), .HBP(2),
                   .VDISPLAY(4), .VFP(1), .VSP(2), .VBP(1),
                   .HSYNC_POL(1), .VSYNC_POL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hc(b_hc), .vc(b_vc),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls), .frame_start(b_fs));

  video_sync_gen u_d (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hc(d_hc), .vc(d_vc),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .line_start(d_ls), .frame_start(d_fs));

  typedef struct {
    int ht; int hd; int hfp; int hsp;
    int vt; int vd; int vfp; int vsp;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    int hc; int vc;
    bit von; bit hs; bit vs; bit ls; bit fs;
  } st_t;

  typedef struct {
    st_t e[3];
  } exp_t;

  typedef struct {
    bit pe; int n;
    int hc; int vc;
    bit von; bit hs; bit vs; bit ls; bit fs;
  } vec_t;

  cfg_t cfg[3];
  st_t  m[3];
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic st_t predict(st_t c, cfg_t k, bit rst, bit pe);
    st_t n = c;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (!rst) begin
      n.hc = k.ht - 1; n.vc = k.vt - 1;
      n.von = 1'b0; n.hs = !k.hp; n.vs = !k.vp;
      return n;
    end
    if (pe) begin
      if (c.hc == k.ht - 1) begin
        n.hc = 0;
        n.vc = (c.vc == k.vt - 1) ? 0 : c.vc + 1;
      end else begin
        n.hc = c.hc + 1;
      end
      n.ls  = (n.hc == 0);
      n.fs  = n.ls && (n.vc == 0);
      n.von = (n.hc < k.hd) && (n.vc < k.vd);
      n.hs  = (n.hc >= k.hd + k.hfp && n.hc <= k.hd + k.hfp + k.hsp - 1) ? k.hp : !k.hp;
      n.vs  = (n.vc >= k.vd + k.vfp && n.vc <= k.vd + k.vfp + k.vsp - 1) ? k.vp : !k.vp;
    end
    return n;
  endfunction

  function automatic st_t sample(int i);
    st_t s;
    case (i)
      0: begin s.hc = int'(a_hc); s.vc = int'(a_vc); s.von = a_von; s.hs = a_hs;
               s.vs = a_vs; s.ls = a_ls; s.fs = a_fs; end
      1: begin s.hc = int'(b_hc); s.vc = int'(b_vc); s.von = b_von; s.hs = b_hs;
               s.vs = b_vs; s.ls = b_ls; s.fs = b_fs; end
      default: begin s.hc = int'(d_hc); s.vc = int'(d_vc); s.von = d_von; s.hs = d_hs;
               s.vs = d_vs; s.ls = d_ls; s.fs = d_fs; end
    endcase
    return s;
  endfunction

  task automatic check_st(string name, int i, st_t e);
    st_t a = sample(i);
    checks++;
    if (a.hc != e.hc || a.vc != e.vc || a.von != e.von || a.hs != e.hs ||
        a.vs != e.vs || a.ls != e.ls || a.fs != e.fs) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got hc=%0d vc=%0d von=%0b hs=%0b vs=%0b ls=%0b fs=%0b, want hc=%0d vc=%0d von=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
               name, i, $time, a.hc, a.vc, a.von, a.hs, a.vs, a.ls, a.fs,
               e.hc, e.vc, e.von, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(bit r, bit pe);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    pix_en = pe;
    for (int i = 0; i < 3; i++) begin
      x.e[i] = predict(m[i], cfg[i], r, pe);
      m[i]   = x.e[i];
    end
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    for (int i = 0; i < 3; i++) check_st("cycle", i, x.e[i]);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = predict(m[i], cfg[i], 1'b0, 1'b0);
      check_st("async_rst", i, m[i]);
    end
  endtask

  vec_t tbl[7];

  initial begin
    int last, nfs, nls, n_vs_lo, n_von, n_dhs_lo;
    st_t e;

    cfg[0] = '{15, 8, 2, 3, 8, 4, 1, 2, 1'b0, 1'b0};
    cfg[1] = '{15, 8, 2, 3, 8, 4, 1, 2, 1'b1, 1'b1};
    cfg[2] = '{800, 640, 16, 96, 525, 480, 10, 2, 1'b0, 1'b0};

    //            pe  n   hc  vc von hs vs ls fs   (instance A, active-low syncs)
    tbl[0] = '{1'b1,  1,  0, 0, 1, 1, 1, 1, 1};
    tbl[1] = '{1'b1, 10, 10, 0, 0, 0, 1, 0, 0};
    tbl[2] = '{1'b0,  5, 10, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{1'b1,  5,  0, 1, 1, 1, 1, 1, 0};
    tbl[4] = '{1'b1, 60,  0, 5, 0, 1, 0, 1, 0};
    tbl[5] = '{1'b1, 12, 12, 5, 0, 0, 0, 0, 0};
    tbl[6] = '{1'b1, 33,  0, 0, 1, 1, 1, 1, 1};

    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = predict(m[i], cfg[i], 1'b0, 1'b0);
      check_st("reset", i, m[i]);
    end
    check_int("b_hsync_in_reset", int'(b_hs), 0);
    check_int("b_vsync_in_reset", int'(b_vs), 0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < tbl[v].n; c++) tick(1'b1, tbl[v].pe);
      e = '{tbl[v].hc, tbl[v].vc, tbl[v].von, tbl[v].hs, tbl[v].vs, tbl[v].ls, tbl[v].fs};
      check_st($sformatf("vec%0d", v), 0, e);
    end

    last = -1; nfs = 0; n_vs_lo = 0; n_von = 0;
    for (int k = 0; k < 260; k++) begin
      tick(1'b1, 1'b1);
      if (k < 120) begin
        n_vs_lo += (a_vs == 1'b0) ? 1 : 0;
        n_von   += a_von ? 1 : 0;
      end
      if (a_fs) begin
        nfs++;
        if (last >= 0) check_int("frame_period", k - last, 120);
        last = k;
      end
    end
    check_int("frame_count", nfs, 2);
    check_int("a_vsync_low_clks", n_vs_lo, 30);
    check_int("a_video_on_clks", n_von, 32);

    nls = 0;
    for (int k = 0; k < 160; k++) begin
      tick(1'b1, (k % 4) == 0);
      nls += a_ls ? 1 : 0;
    end
    check_int("div4_line_starts", nls, 3);

    n_dhs_lo = 0;
    for (int k = 0; k < 1700; k++) begin
      tick(1'b1, 1'b1);
      if (k >= 100 && k < 900) n_dhs_lo += (d_hs == 1'b0) ? 1 : 0;
    end
    check_int("d_hsync_low_per_line", n_dhs_lo, 96);

    for (int k = 0; k < 37; k++) tick(1'b1, 1'b1);
    async_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_int("post_rst_frame_start", int'(a_fs), 1);
    check_int("post_rst_d_frame_start", int'(d_fs), 1);
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
